uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised receive buffer for the UART, sitting between the RX deserialiser and the register file.
//  Stores each character with its rx_err_s flags and drives the LSR bits DR, OE and FIFO-err.
//  Raises the trigger-level and character-timeout interrupt causes.
//  Generalises the fixed 16-deep 16550 FIFO: depth, trigger levels and timeout length are parameters.
// PARAMETERS
//  DEPTH          16  entries; power of two, >= 2
//  DATA_W          8  character width
//  TRIG_L0         1  level selected by FIFO_TRIG_1
//  TRIG_L1         4  level selected by FIFO_TRIG_4
//  TRIG_L2         8  level selected by FIFO_TRIG_8
//  TRIG_L3        14  level selected by FIFO_TRIG_14; every TRIG_Lx must lie in 1..DEPTH
//  TIMEOUT_CHARS   4  idle character times before timeout_int
// PORTS
//  clk          in   1             system clock
//  rst_n        in   1             asynchronous active-low reset
//  fifo_en      in   1             FCR[0]; 0 = 16450 single-holding-register mode
//  fifo_clr     in   1             FCR[1] write pulse; flush contents
//  trig_sel     in   fifo_trig_e   FCR[7:6]
//  char_tick    in   1             one-cycle pulse per character time, from the baud generator
//  push_valid   in   1             deserialiser has a completed character
//  push_data    in   DATA_W        received character
//  push_err     in   rx_err_s      flags for that character
//  pop          in   1             RBR read strobe
//  lsr_rd       in   1             LSR read strobe
//  rd_data      out  DATA_W        head character (first-word fall-through)
//  rd_err       out  rx_err_s      head flags; 0 when empty
//  data_ready   out  1             LSR[0]: count != 0
//  overrun      out  1             LSR[1], sticky
//  fifo_err     out  1             LSR[7]: any stored entry has a nonzero error
//  trig_hit     out  1             count >= selected level (FIFO mode only)
//  timeout_int  out  1             character timeout pending
//  count        out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset: pointers, count, error-entry count, timeout counter and overrun all 0. All outputs 0.
//  - Push is registered and visible the next cycle. Pop removes the head at the clock edge.
//    rd_data/rd_err are combinational from the head entry.
//  - Capacity: DEPTH when fifo_en=1, 1 when fifo_en=0.
//  - Push when count < capacity: store the entry.
//  - Push when full, FIFO mode: drop the new character and set overrun. Contents are unchanged.
//  - Push when full, non-FIFO mode: overwrite the single entry and set overrun.
//  - Push and pop in the same cycle: the pop is applied first.
//    When full, both are accepted, count is unchanged and overrun is not set.
//    When empty, the pop is ignored and the push is stored.
//  - Pop when empty: no effect.
//  - Pointers wrap modulo DEPTH; count is one bit wider than the pointers, so full and empty are distinct.
//  - overrun clears on lsr_rd. If lsr_rd and a new overrun coincide, the set wins.
//  - fifo_err tracking: err_cnt is incremented on a stored push with push_err != 0 and decremented on a pop of a nonzero-error head.
//    fifo_err = fifo_en && err_cnt != 0.
//  - trig_hit = fifo_en && count >= TRIG_L[trig_sel].
//  - Timeout counter, FIFO mode only:
//    . Cleared when count == 0, on any push or pop, and in non-FIFO mode.
//    . Otherwise incremented on char_tick, saturating at TIMEOUT_CHARS.
//    . timeout_int = (counter == TIMEOUT_CHARS) && count != 0.
//  - Flush: fifo_clr, or any change of fifo_en (edge detected against a registered copy), empties the FIFO.
//    It clears count, err_cnt and the timeout counter in one cycle, and wins over a same-cycle push or pop. overrun is unchanged.
//  - rst_n asserted mid-operation discards everything asynchronously.
// STRUCTURE
//  - uart_pkg gains:
//    . rx_entry_s {rx_err_s err; logic [7:0] data}
//    . localparam RX_TIMEOUT_CHARS_DEFAULT = 4
//    . a function trig_level(fifo_trig_e) returning the default levels.
//  - One sub-module, uart_sync_fifo: generic DEPTH x W storage with pointers and count.
//    Overrun, error counting, trigger and timeout logic stay in uart_rx_fifo.
// TESTING
//  1. FIFO mode, trig_sel=FIFO_TRIG_4:
//     push 0x41..0x44 -> trig_hit rises after the 4th push, count=4.
//     Pop 4 times -> rd_data 0x41..0x44 in order, data_ready=0.
//  2. Fill 16, then push 0x99 -> overrun=1, count=16, last pop returns the 16th char, not 0x99.
//     lsr_rd -> overrun=0.
//  3. Push 0x10 with frame_err, then 0x11 clean -> fifo_err=1.
//     Pop once -> fifo_err=0, rd_err=0.
//  4. Push one char, no further activity, apply 4 char_tick -> timeout_int=1 on the 4th.
//     Pop -> timeout_int=0.
//  5. fifo_en=0: push 0x55 then 0x66 -> overrun=1, rd_data=0x66, count=1.
//     Toggle fifo_en -> count=0.
//  6. Full FIFO, push+pop same cycle -> count stays 16, overrun=0.
//     fifo_clr with push in the same cycle -> count=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: receive error flags, FCR trigger encodings and the RX FIFO entry layout.
package uart_pkg;

  typedef enum logic [1:0] {
    FIFO_TRIG_1  = 2'd0,
    FIFO_TRIG_4  = 2'd1,
    FIFO_TRIG_8  = 2'd2,
    FIFO_TRIG_14 = 2'd3
  } fifo_trig_e;

  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } rx_err_s;

  typedef struct packed {
    rx_err_s    err;
    logic [7:0] data;
  } rx_entry_s;

  localparam int unsigned RX_TIMEOUT_CHARS_DEFAULT = 4;
  localparam int unsigned RX_FIFO_DEPTH_DEFAULT    = 16;

  // Classic 16550 trigger levels for each FCR[7:6] encoding.
  function automatic int unsigned trig_level(fifo_trig_e sel);
    int unsigned lvl;
    case (sel)
      FIFO_TRIG_1:  lvl = 1;
      FIFO_TRIG_4:  lvl = 4;
      FIFO_TRIG_8:  lvl = 8;
      FIFO_TRIG_14: lvl = 14;
      default:      lvl = 1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic DEPTH x W synchronous storage with wrapping pointers and a one-bit-wider occupancy count.
// The caller decides acceptance; wr_en/rd_en are applied unconditionally.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: stores characters with their error flags, drives LSR DR/OE/FIFO-err,
// and raises the trigger-level and character-timeout interrupt causes.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH         = RX_FIFO_DEPTH_DEFAULT,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned TRIG_L0       = trig_level(FIFO_TRIG_1),
  parameter int unsigned TRIG_L1       = trig_level(FIFO_TRIG_4),
  parameter int unsigned TRIG_L2       = trig_level(FIFO_TRIG_8),
  parameter int unsigned TRIG_L3       = trig_level(FIFO_TRIG_14),
  parameter int unsigned TIMEOUT_CHARS = RX_TIMEOUT_CHARS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_en,
  input  logic                   fifo_clr,
  input  fifo_trig_e             trig_sel,
  input  logic                   char_tick,
  input  logic                   push_valid,
  input  logic [DATA_W-1:0]      push_data,
  input  rx_err_s                push_err,
  input  logic                   pop,
  input  logic                   lsr_rd,
  output logic [DATA_W-1:0]      rd_data,
  output rx_err_s                rd_err,
  output logic                   data_ready,
  output logic                   overrun,
  output logic                   fifo_err,
  output logic                   trig_hit,
  output logic                   timeout_int,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(rx_err_s);
  localparam int unsigned W  = DATA_W + EW;
  localparam int unsigned TW = $clog2(TIMEOUT_CHARS + 1);

  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LVL0      = CW'(TRIG_L0);
  localparam logic [CW-1:0] LVL1      = CW'(TRIG_L1);
  localparam logic [CW-1:0] LVL2      = CW'(TRIG_L2);
  localparam logic [CW-1:0] LVL3      = CW'(TRIG_L3);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CHARS);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  logic              fifo_en_q;
  logic              flush;
  logic              empty;
  logic              full;
  logic              pop_eff;
  logic              push_store;
  logic              ovr_set;
  logic              head_remove;
  logic              err_inc;
  logic              err_dec;
  logic [W-1:0]      wr_entry;
  logic [W-1:0]      head;
  rx_err_s           head_err;
  logic [DATA_W-1:0] head_data;
  logic [CW-1:0]     err_cnt;
  logic [CW-1:0]     trig_lvl;
  logic [TW-1:0]     tmo_cnt;

  assign flush = fifo_clr || (fifo_en != fifo_en_q);
  assign empty = (count == '0);

  assign wr_entry  = {push_err, push_data};
  assign head_err  = rx_err_s'(head[W-1 -: EW]);
  assign head_data = head[DATA_W-1:0];

  // Non-FIFO overwrite is performed as a head removal plus a store, so the
  // single slot and the error-entry count stay consistent with FIFO mode.
  always_comb begin
    full        = fifo_en ? (count == CNT_DEPTH) : !empty;
    pop_eff     = !flush && pop && !empty;
    push_store  = !flush && push_valid && (!full || pop_eff || !fifo_en);
    ovr_set     = !flush && push_valid && full && !pop_eff;
    head_remove = pop_eff || (ovr_set && !fifo_en);
    err_inc     = push_store && (push_err != '0);
    err_dec     = head_remove && (head_err != '0);
  end

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (push_store),
    .wr_data (wr_entry),
    .rd_en   (head_remove),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_en_q <= 1'b0;
    end else begin
      fifo_en_q <= fifo_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (lsr_rd) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (flush) begin
      err_cnt <= '0;
    end else begin
      case ({err_inc, err_dec})
        2'b10:   err_cnt <= err_cnt + CNT_ONE;
        2'b01:   err_cnt <= err_cnt - CNT_ONE;
        default: err_cnt <= err_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (flush || !fifo_en || empty || push_valid || pop) begin
      tmo_cnt <= '0;
    end else if (char_tick && (tmo_cnt != TMO_MAX)) begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  always_comb begin
    trig_lvl = LVL0;
    case (trig_sel)
      FIFO_TRIG_1:  trig_lvl = LVL0;
      FIFO_TRIG_4:  trig_lvl = LVL1;
      FIFO_TRIG_8:  trig_lvl = LVL2;
      FIFO_TRIG_14: trig_lvl = LVL3;
      default:      trig_lvl = LVL0;
    endcase
  end

  assign rd_data     = empty ? '0 : head_data;
  assign rd_err      = empty ? '0 : head_err;
  assign data_ready  = !empty;
  assign fifo_err    = fifo_en && (err_cnt != '0);
  assign trig_hit    = fifo_en && (count >= trig_lvl);
  assign timeout_int = (tmo_cnt == TMO_MAX) && !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_en = 1'b0;
  logic       fifo_clr = 1'b0;
  fifo_trig_e trig_sel = FIFO_TRIG_1;
  logic       char_tick = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = '0;
  rx_err_s    push_err = '0;
  logic       pop = 1'b0;
  logic       lsr_rd = 1'b0;

  logic [7:0] rd_data;
  rx_err_s    rd_err;
  logic       data_ready, overrun, fifo_err, trig_hit, timeout_int;
  logic [4:0] count;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8), .TIMEOUT_CHARS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_en(fifo_en), .fifo_clr(fifo_clr),
    .trig_sel(trig_sel), .char_tick(char_tick), .push_valid(push_valid),
    .push_data(push_data), .push_err(push_err), .pop(pop), .lsr_rd(lsr_rd),
    .rd_data(rd_data), .rd_err(rd_err), .data_ready(data_ready),
    .overrun(overrun), .fifo_err(fifo_err), .trig_hit(trig_hit),
    .timeout_int(timeout_int), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] err;
    logic [7:0] data;
  } ent_t;

  ent_t q[$];
  bit   m_ov;
  int   m_tm;
  bit   m_fenq;
  int   levels[4] = '{1, 4, 8, 14};
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 0;
    m_tm = 0;
    m_fenq = 0;
  endtask

  task automatic check_all();
    int   sz;
    bit   any_err;
    ent_t h;
    sz = q.size();
    any_err = 0;
    foreach (q[i]) if (q[i].err != 3'b000) any_err = 1;
    h.err = 3'b000;
    h.data = 8'h00;
    if (sz > 0) h = q[0];
    chk("count", 32'(count), 32'(sz));
    chk("data_ready", 32'(data_ready), 32'(sz != 0));
    chk("rd_data", 32'(rd_data), 32'(h.data));
    chk("rd_err", 32'(rd_err), 32'(h.err));
    chk("overrun", 32'(overrun), 32'(m_ov));
    chk("fifo_err", 32'(fifo_err), 32'(fifo_en && any_err));
    chk("trig_hit", 32'(trig_hit), 32'(fifo_en && (sz >= levels[int'(trig_sel)])));
    chk("timeout_int", 32'(timeout_int), 32'((m_tm == TMO) && (sz != 0)));
  endtask

  // Applies the buffer's rules to the inputs that were sampled at the edge just taken.
  task automatic model_step();
    int   sz;
    int   cap;
    bit   set;
    ent_t e;
    sz = q.size();
    cap = fifo_en ? DEPTH : 1;
    set = 0;
    e.err = push_err;
    e.data = push_data;
    if (fifo_clr || (fifo_en != m_fenq)) begin
      q.delete();
      m_tm = 0;
    end else begin
      if (!fifo_en || sz == 0 || push_valid || pop) m_tm = 0;
      else if (char_tick && m_tm < TMO) m_tm++;
      if (pop && q.size() > 0) void'(q.pop_front());
      if (push_valid) begin
        if (q.size() < cap) q.push_back(e);
        else if (fifo_en) set = 1;
        else begin
          q[0] = e;
          set = 1;
        end
      end
    end
    if (set) m_ov = 1;
    else if (lsr_rd) m_ov = 0;
    m_fenq = fifo_en;
  endtask

  task automatic drive(input bit pv, input logic [7:0] d, input logic [2:0] er,
                       input bit pp, input bit lr, input bit tk, input bit clr);
    push_valid = pv;
    push_data  = d;
    push_err   = er;
    pop        = pp;
    lsr_rd     = lr;
    char_tick  = tk;
    fifo_clr   = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    push_valid = 0;
    pop = 0;
    lsr_rd = 0;
    char_tick = 0;
    fifo_clr = 0;
  endtask

  task automatic idle();
    drive(0, 8'h00, 3'b000, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    chk("reset_count", 32'(count), 32'd0);
    #1 rst_n = 1'b1;
    fifo_en = 1'b1;
    idle();

    // 1: trigger level 4 and in-order readout
    trig_sel = FIFO_TRIG_4;
    for (int i = 0; i < 4; i++) begin
      chk("t1_trig_low", 32'(trig_hit), 32'd0);
      drive(1, 8'h41 + 8'(i), 3'b000, 0, 0, 0, 0);
    end
    chk("t1_trig", 32'(trig_hit), 32'd1);
    chk("t1_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_order", 32'(rd_data), 32'h41 + 32'(i));
      drive(0, 8'h00, 3'b000, 1, 0, 0, 0);
    end
    chk("t1_dr", 32'(data_ready), 32'd0);

    // 2: overrun on full keeps contents
    for (int i = 0; i < 16; i++) drive(1, 8'h20 + 8'(i), 3'b000, 0, 0, 0, 0);
    drive(1, 8'h99, 3'b000, 0, 0, 0, 0);
    chk("t2_ovr", 32'(overrun), 32'd1);
    chk("t2_count", 32'(count), 32'd16);
    for (int i = 0; i < 15; i++) drive(0, 8'h00, 3'b000, 1, 0, 0, 0);
    chk("t2_last", 32'(rd_data), 32'h2f);
    drive(0, 8'h00, 3'b000, 1, 0, 0, 0);
    drive(0, 8'h00, 3'b000, 0, 1, 0, 0);
    chk("t2_ovr_clr", 32'(overrun), 32'd0);

    // 3: error tracking
    drive(1, 8'h10, 3'b010, 0, 0, 0, 0);
    drive(1, 8'h11, 3'b000, 0, 0, 0, 0);
    chk("t3_ferr", 32'(fifo_err), 32'd1);
    drive(0, 8'h00, 3'b000, 1, 0, 0, 0);
    chk("t3_ferr_clr", 32'(fifo_err), 32'd0);
    chk("t3_rd_err", 32'(rd_err), 32'd0);
    drive(0, 8'h00, 3'b000, 1, 0, 0, 0);

    // 4: character timeout
    drive(1, 8'h77, 3'b000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 8'h00, 3'b000, 0, 0, 1, 0);
    chk("t4_tmo_early", 32'(timeout_int), 32'd0);
    drive(0, 8'h00, 3'b000, 0, 0, 1, 0);
    chk("t4_tmo", 32'(timeout_int), 32'd1);
    drive(0, 8'h00, 3'b000, 1, 0, 0, 0);
    chk("t4_tmo_clr", 32'(timeout_int), 32'd0);

    // 5: single holding register mode
    fifo_en = 1'b0;
    idle();
    drive(1, 8'h55, 3'b000, 0, 0, 0, 0);
    drive(1, 8'h66, 3'b000, 0, 0, 0, 0);
    chk("t5_ovr", 32'(overrun), 32'd1);
    chk("t5_data", 32'(rd_data), 32'h66);
    chk("t5_count", 32'(count), 32'd1);
    drive(0, 8'h00, 3'b000, 0, 1, 0, 0);
    fifo_en = 1'b1;
    idle();
    chk("t5_flush", 32'(count), 32'd0);

    // 6: full push+pop, then clear beating push
    for (int i = 0; i < 16; i++) drive(1, 8'h60 + 8'(i), 3'b001, 0, 0, 0, 0);
    drive(1, 8'hA5, 3'b000, 1, 0, 0, 0);
    chk("t6_count", 32'(count), 32'd16);
    chk("t6_ovr", 32'(overrun), 32'd0);
    drive(1, 8'hB6, 3'b000, 0, 0, 0, 1);
    chk("t6_clr", 32'(count), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 1) fifo_en = ~fifo_en;
      if ($urandom_range(0, 99) < 5) trig_sel = fifo_trig_e'($urandom_range(0, 3));
      drive(($urandom_range(0, 99) < 50), 8'($urandom), 3'($urandom_range(0, 7) < 2 ? $urandom : 0),
            ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 2));
    end

    // asynchronous reset mid-operation
    fifo_en = 1'b1;
    idle();
    for (int i = 0; i < 5; i++) drive(1, 8'(i), 3'b100, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_rst_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
